// File: rtl/ldst_pkg.sv
// ldst_pkg: shared types and helpers for the load/store execute stage.
//   LDST_*_W    : datapath widths used by the completion buffer entry type
//   cb_entry_t  : one completion buffer slot
//   br_squash() : 1 when an op's branch mask depends on the resolved branch
package ldst_pkg;

    localparam int unsigned LDST_DATA_W    = 64;
    localparam int unsigned LDST_PRF_IDX_W = 6;
    localparam int unsigned LDST_ROB_IDX_W = 5;
    localparam int unsigned LDST_BR_MASK_W = 4;

    typedef struct packed {
        logic                      vld;
        logic                      is_st;
        logic [LDST_DATA_W-1:0]    data;
        logic [LDST_PRF_IDX_W-1:0] dest_tag;
        logic [LDST_ROB_IDX_W:0]   rob_idx;
        logic [LDST_BR_MASK_W-1:0] br_mask;
    } cb_entry_t;

    function automatic logic br_squash(input logic [LDST_BR_MASK_W-1:0] mask,
                                       input logic [LDST_BR_MASK_W-1:0] fix);
        return |(mask & fix);
    endfunction

endpackage

// File: rtl/ldst_cmp_fifo.sv
// ldst_cmp_fifo: DEPTH-entry circular completion buffer between the LSQ and the
// CDB/ROB writeback port, with branch-mask squash and resolved-bit clearing.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   br_recovery_i/pred_correct_i : branch resolved mispredicted / correct
//   br_tag_fix_i                 : one-hot resolved branch bit
//   cmp_*_i                      : LSQ completion (enqueue side)
//   cb_full_o, cb_count_o        : occupancy (holes included)
//   wb_rdy_i                     : CDB grant
//   wb_vld_o, ld_done_o, st_done_o, result_o, dest_tag_o, rob_idx_o, br_mask_o
//                                : head entry, all zero when the head is not valid
module ldst_cmp_fifo
    import ldst_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        br_recovery_i,
    input  logic                        br_pred_correct_i,
    input  logic [LDST_BR_MASK_W-1:0]   br_tag_fix_i,
    input  logic                        cmp_vld_i,
    input  logic                        cmp_is_st_i,
    input  logic [LDST_DATA_W-1:0]      cmp_data_i,
    input  logic [LDST_PRF_IDX_W-1:0]   cmp_dest_tag_i,
    input  logic [LDST_ROB_IDX_W:0]     cmp_rob_idx_i,
    input  logic [LDST_BR_MASK_W-1:0]   cmp_br_mask_i,
    output logic                        cb_full_o,
    output logic [$clog2(DEPTH):0]      cb_count_o,
    input  logic                        wb_rdy_i,
    output logic                        wb_vld_o,
    output logic                        ld_done_o,
    output logic                        st_done_o,
    output logic [LDST_DATA_W-1:0]      result_o,
    output logic [LDST_PRF_IDX_W-1:0]   dest_tag_o,
    output logic [LDST_ROB_IDX_W:0]     rob_idx_o,
    output logic [LDST_BR_MASK_W-1:0]   br_mask_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    cb_entry_t                 r_mem [DEPTH];
    cb_entry_t                 w_mem_d [DEPTH];
    cb_entry_t                 w_head;
    logic [PTR_W-1:0]          r_head;
    logic [PTR_W-1:0]          r_tail;
    logic [CNT_W-1:0]          r_count;
    logic [CNT_W-1:0]          w_count_d;
    logic                      w_full;
    logic                      w_push;
    logic                      w_pop;
    logic [LDST_BR_MASK_W-1:0] w_clr;

    assign w_head = r_mem[r_head];

    always_comb begin
        w_full = (r_count == CNT_W'(DEPTH));
        // A squashed (invalid) head is a hole: it drains without a CDB grant.
        w_pop  = (r_count != '0) && (!w_head.vld || wb_rdy_i);
        w_push = cmp_vld_i && !w_full
                 && !(br_recovery_i && br_squash(cmp_br_mask_i, br_tag_fix_i));
        w_clr  = br_pred_correct_i ? br_tag_fix_i : '0;

        for (int i = 0; i < DEPTH; i++) begin
            w_mem_d[i] = r_mem[i];
            if (br_recovery_i && br_squash(r_mem[i].br_mask, br_tag_fix_i)) begin
                w_mem_d[i].vld = 1'b0;
            end
            w_mem_d[i].br_mask = r_mem[i].br_mask & ~w_clr;
        end

        if (w_pop) begin
            w_mem_d[r_head].vld = 1'b0;
        end
        // Push never targets the popped slot: head == tail only when empty or full.
        if (w_push) begin
            w_mem_d[r_tail].vld      = 1'b1;
            w_mem_d[r_tail].is_st    = cmp_is_st_i;
            w_mem_d[r_tail].data     = cmp_is_st_i ? '0 : cmp_data_i;
            w_mem_d[r_tail].dest_tag = cmp_dest_tag_i;
            w_mem_d[r_tail].rob_idx  = cmp_rob_idx_i;
            w_mem_d[r_tail].br_mask  = cmp_br_mask_i & ~w_clr;
        end

        w_count_d = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= w_mem_d[i];
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            r_count <= w_count_d;
        end
    end

    always_comb begin
        cb_full_o  = w_full;
        cb_count_o = r_count;
        wb_vld_o   = w_head.vld;
        ld_done_o  = w_head.vld && !w_head.is_st;
        st_done_o  = w_head.vld && w_head.is_st;
        result_o   = w_head.vld ? w_head.data     : '0;
        dest_tag_o = w_head.vld ? w_head.dest_tag : '0;
        rob_idx_o  = w_head.vld ? w_head.rob_idx  : '0;
        br_mask_o  = w_head.vld ? w_head.br_mask  : '0;
    end

endmodule

// File: rtl/fu_ldst_cb.sv
// fu_ldst_cb: load/store execute stage. Registered AGU toward the LSQ plus a
// completion buffer (ldst_cmp_fifo) toward the CDB/ROB writeback port.
// Build option: define LDST_MISALIGN_CHK_EN to build the registered size-alignment
// check; otherwise agu_misalign_o is tied to 0.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   rob_br_recovery_i/_pred_correct_i, rob_br_tag_fix_i : branch resolution
//   agu_*_i / agu_*_o                : issue in, registered issue to LSQ
//   cmp_*_i, cb_full_o, cb_count_o   : LSQ completion in, buffer occupancy
//   wb_rdy_i, wb_vld_o ... br_mask_o : writeback to CDB/ROB
// Widths are fixed by ldst_pkg; the parameters must match the package values.
module fu_ldst_cb
    import ldst_pkg::*;
#(
    parameter int unsigned DATA_W    = LDST_DATA_W,
    parameter int unsigned PRF_IDX_W = LDST_PRF_IDX_W,
    parameter int unsigned ROB_IDX_W = LDST_ROB_IDX_W,
    parameter int unsigned BR_MASK_W = LDST_BR_MASK_W,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rob_br_recovery_i,
    input  logic                   rob_br_pred_correct_i,
    input  logic [BR_MASK_W-1:0]   rob_br_tag_fix_i,
    input  logic                   agu_vld_i,
    input  logic                   agu_is_st_i,
    input  logic [DATA_W-1:0]      opa_i,
    input  logic [DATA_W-1:0]      opb_i,
    input  logic [31:0]            inst_i,
    input  logic [1:0]             size_i,
    input  logic [BR_MASK_W-1:0]   agu_br_mask_i,
    input  logic                   agu_stall_i,
    output logic                   agu_vld_o,
    output logic                   agu_is_st_o,
    output logic [DATA_W-1:0]      agu_addr_o,
    output logic [DATA_W-1:0]      agu_st_data_o,
    output logic [BR_MASK_W-1:0]   agu_br_mask_o,
    output logic                   agu_misalign_o,
    input  logic                   cmp_vld_i,
    input  logic                   cmp_is_st_i,
    input  logic [DATA_W-1:0]      cmp_data_i,
    input  logic [PRF_IDX_W-1:0]   cmp_dest_tag_i,
    input  logic [ROB_IDX_W:0]     cmp_rob_idx_i,
    input  logic [BR_MASK_W-1:0]   cmp_br_mask_i,
    output logic                   cb_full_o,
    output logic [$clog2(DEPTH):0] cb_count_o,
    input  logic                   wb_rdy_i,
    output logic                   wb_vld_o,
    output logic                   ld_done_o,
    output logic                   st_done_o,
    output logic [DATA_W-1:0]      result_o,
    output logic [PRF_IDX_W-1:0]   dest_tag_o,
    output logic [ROB_IDX_W:0]     rob_idx_o,
    output logic [BR_MASK_W-1:0]   br_mask_o
);

    logic                 r_vld;
    logic                 r_is_st;
    logic [DATA_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_st_data;
    logic [BR_MASK_W-1:0] r_br_mask;
    logic [DATA_W-1:0]    w_disp;
    logic [DATA_W-1:0]    w_addr;
    logic [BR_MASK_W-1:0] w_clr;
    logic                 w_agu_kill;
    logic                 w_unused_inst;

    assign w_disp        = {{(DATA_W-16){inst_i[15]}}, inst_i[15:0]};
    assign w_addr        = opb_i + w_disp;
    assign w_clr         = rob_br_pred_correct_i ? rob_br_tag_fix_i : '0;
    assign w_agu_kill    = rob_br_recovery_i && br_squash(r_br_mask, rob_br_tag_fix_i);
    assign w_unused_inst = ^inst_i[31:16];

    // Any recovery takes priority over loading, so a newly issued op is never
    // captured during a recovery cycle and needs no squash check of its own.
    always_ff @(posedge clk) begin
        if (rst || w_agu_kill) begin
            r_vld     <= 1'b0;
            r_is_st   <= 1'b0;
            r_addr    <= '0;
            r_st_data <= '0;
            r_br_mask <= '0;
        end else if (rob_br_recovery_i) begin
            r_vld <= r_vld;
        end else if (!agu_stall_i) begin
            r_vld     <= agu_vld_i;
            r_is_st   <= agu_is_st_i;
            r_addr    <= w_addr;
            r_st_data <= opa_i;
            r_br_mask <= agu_br_mask_i & ~w_clr;
        end else begin
            r_br_mask <= r_br_mask & ~w_clr;
        end
    end

    assign agu_vld_o     = r_vld;
    assign agu_is_st_o   = r_is_st;
    assign agu_addr_o    = r_addr;
    assign agu_st_data_o = r_st_data;
    assign agu_br_mask_o = r_br_mask;

`ifdef LDST_MISALIGN_CHK_EN
    logic       r_misalign;
    logic [2:0] w_align_mask;

    always_comb begin
        w_align_mask = 3'b000;
        unique case (size_i)
            2'd0: w_align_mask = 3'b000;
            2'd1: w_align_mask = 3'b001;
            2'd2: w_align_mask = 3'b011;
            2'd3: w_align_mask = 3'b111;
            default: w_align_mask = 3'b000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || w_agu_kill) begin
            r_misalign <= 1'b0;
        end else if (rob_br_recovery_i) begin
            r_misalign <= r_misalign;
        end else if (!agu_stall_i) begin
            r_misalign <= |(w_addr[2:0] & w_align_mask);
        end
    end

    assign agu_misalign_o = r_misalign;
`else
    logic w_unused_size;
    assign w_unused_size  = ^size_i;
    assign agu_misalign_o = 1'b0;
`endif

    ldst_cmp_fifo #(
        .DEPTH (DEPTH)
    ) u_cmp_fifo (
        .clk               (clk),
        .rst               (rst),
        .br_recovery_i     (rob_br_recovery_i),
        .br_pred_correct_i (rob_br_pred_correct_i),
        .br_tag_fix_i      (rob_br_tag_fix_i),
        .cmp_vld_i         (cmp_vld_i),
        .cmp_is_st_i       (cmp_is_st_i),
        .cmp_data_i        (cmp_data_i),
        .cmp_dest_tag_i    (cmp_dest_tag_i),
        .cmp_rob_idx_i     (cmp_rob_idx_i),
        .cmp_br_mask_i     (cmp_br_mask_i),
        .cb_full_o         (cb_full_o),
        .cb_count_o        (cb_count_o),
        .wb_rdy_i          (wb_rdy_i),
        .wb_vld_o          (wb_vld_o),
        .ld_done_o         (ld_done_o),
        .st_done_o         (st_done_o),
        .result_o          (result_o),
        .dest_tag_o        (dest_tag_o),
        .rob_idx_o         (rob_idx_o),
        .br_mask_o         (br_mask_o)
    );

endmodule

// File: tb/tb_fu_ldst_cb.sv
// Directed testbench for fu_ldst_cb with default parameters.
module tb_fu_ldst_cb;

    logic        clk = 1'b0;
    logic        rst;
    logic        rob_br_recovery_i, rob_br_pred_correct_i;
    logic [3:0]  rob_br_tag_fix_i;
    logic        agu_vld_i, agu_is_st_i;
    logic [63:0] opa_i, opb_i;
    logic [31:0] inst_i;
    logic [1:0]  size_i;
    logic [3:0]  agu_br_mask_i;
    logic        agu_stall_i;
    logic        agu_vld_o, agu_is_st_o;
    logic [63:0] agu_addr_o, agu_st_data_o;
    logic [3:0]  agu_br_mask_o;
    logic        agu_misalign_o;
    logic        cmp_vld_i, cmp_is_st_i;
    logic [63:0] cmp_data_i;
    logic [5:0]  cmp_dest_tag_i;
    logic [5:0]  cmp_rob_idx_i;
    logic [3:0]  cmp_br_mask_i;
    logic        cb_full_o;
    logic [2:0]  cb_count_o;
    logic        wb_rdy_i;
    logic        wb_vld_o, ld_done_o, st_done_o;
    logic [63:0] result_o;
    logic [5:0]  dest_tag_o;
    logic [5:0]  rob_idx_o;
    logic [3:0]  br_mask_o;

    int n_vec  = 0;
    int n_fail = 0;
    logic exp_mis3;

    always #5 clk = ~clk;

    fu_ldst_cb dut (
        .clk                   (clk),
        .rst                   (rst),
        .rob_br_recovery_i     (rob_br_recovery_i),
        .rob_br_pred_correct_i (rob_br_pred_correct_i),
        .rob_br_tag_fix_i      (rob_br_tag_fix_i),
        .agu_vld_i             (agu_vld_i),
        .agu_is_st_i           (agu_is_st_i),
        .opa_i                 (opa_i),
        .opb_i                 (opb_i),
        .inst_i                (inst_i),
        .size_i                (size_i),
        .agu_br_mask_i         (agu_br_mask_i),
        .agu_stall_i           (agu_stall_i),
        .agu_vld_o             (agu_vld_o),
        .agu_is_st_o           (agu_is_st_o),
        .agu_addr_o            (agu_addr_o),
        .agu_st_data_o         (agu_st_data_o),
        .agu_br_mask_o         (agu_br_mask_o),
        .agu_misalign_o        (agu_misalign_o),
        .cmp_vld_i             (cmp_vld_i),
        .cmp_is_st_i           (cmp_is_st_i),
        .cmp_data_i            (cmp_data_i),
        .cmp_dest_tag_i        (cmp_dest_tag_i),
        .cmp_rob_idx_i         (cmp_rob_idx_i),
        .cmp_br_mask_i         (cmp_br_mask_i),
        .cb_full_o             (cb_full_o),
        .cb_count_o            (cb_count_o),
        .wb_rdy_i              (wb_rdy_i),
        .wb_vld_o              (wb_vld_o),
        .ld_done_o             (ld_done_o),
        .st_done_o             (st_done_o),
        .result_o              (result_o),
        .dest_tag_o            (dest_tag_o),
        .rob_idx_o             (rob_idx_o),
        .br_mask_o             (br_mask_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cmp(input logic is_st, input logic [63:0] data, input logic [5:0] tag,
                       input logic [5:0] rob, input logic [3:0] mask);
        cmp_vld_i      = 1'b1;
        cmp_is_st_i    = is_st;
        cmp_data_i     = data;
        cmp_dest_tag_i = tag;
        cmp_rob_idx_i  = rob;
        cmp_br_mask_i  = mask;
    endtask

    initial begin
`ifdef LDST_MISALIGN_CHK_EN
        exp_mis3 = 1'b1;
`else
        exp_mis3 = 1'b0;
`endif
        rst = 1'b1;
        rob_br_recovery_i = 0; rob_br_pred_correct_i = 0; rob_br_tag_fix_i = 0;
        agu_vld_i = 0; agu_is_st_i = 0; opa_i = 0; opb_i = 0; inst_i = 0; size_i = 0;
        agu_br_mask_i = 0; agu_stall_i = 0;
        cmp_vld_i = 0; cmp_is_st_i = 0; cmp_data_i = 0; cmp_dest_tag_i = 0;
        cmp_rob_idx_i = 0; cmp_br_mask_i = 0; wb_rdy_i = 0;
        tick();
        tick();
        chk("rst_agu_vld", agu_vld_o, 0);
        chk("rst_agu_addr", agu_addr_o, 0);
        chk("rst_misalign", agu_misalign_o, 0);
        chk("rst_count", cb_count_o, 0);
        chk("rst_full", cb_full_o, 0);
        chk("rst_wb_vld", wb_vld_o, 0);
        rst = 1'b0;

        // AGU: negative displacement
        agu_vld_i = 1; opa_i = 64'hAA; opb_i = 64'h1000; inst_i = 32'h0000_FFF8;
        size_i = 3; agu_br_mask_i = 4'b0011;
        tick();
        chk("agu_vld", agu_vld_o, 1);
        chk("agu_addr", agu_addr_o, 64'hFF8);
        chk("agu_is_st", agu_is_st_o, 0);
        chk("agu_mask", agu_br_mask_o, 4'b0011);

        // Stall 3 cycles, pred_correct on bit 0 in the middle
        agu_stall_i = 1; agu_vld_i = 0; opb_i = 64'h2000;
        tick();
        chk("stall_vld", agu_vld_o, 1);
        chk("stall_addr", agu_addr_o, 64'hFF8);
        rob_br_pred_correct_i = 1; rob_br_tag_fix_i = 4'b0001;
        tick();
        chk("stall_clr_mask", agu_br_mask_o, 4'b0010);
        rob_br_pred_correct_i = 0; rob_br_tag_fix_i = 0;
        tick();
        chk("stall_hold_vld", agu_vld_o, 1);
        chk("stall_hold_mask", agu_br_mask_o, 4'b0010);
        agu_stall_i = 0;
        tick();
        chk("unstall_vld", agu_vld_o, 0);
        chk("unstall_addr", agu_addr_o, 64'h1FF8);

        // Store issue, recovery no-match holds, match clears
        agu_vld_i = 1; agu_is_st_i = 1; opa_i = 64'h1234; opb_i = 64'h100;
        inst_i = 32'h0000_0010; agu_br_mask_i = 4'b0100;
        tick();
        chk("st_is_st", agu_is_st_o, 1);
        chk("st_data", agu_st_data_o, 64'h1234);
        chk("st_addr", agu_addr_o, 64'h110);
        agu_vld_i = 0; agu_is_st_i = 0;
        rob_br_recovery_i = 1; rob_br_tag_fix_i = 4'b1000;
        tick();
        chk("rec_nomatch_vld", agu_vld_o, 1);
        chk("rec_nomatch_addr", agu_addr_o, 64'h110);
        rob_br_tag_fix_i = 4'b0100;
        tick();
        chk("rec_match_vld", agu_vld_o, 0);
        chk("rec_match_data", agu_st_data_o, 0);
        chk("rec_match_mask", agu_br_mask_o, 0);
        rob_br_recovery_i = 0; rob_br_tag_fix_i = 0;

        // Misalignment and address wrap
        agu_vld_i = 1; opb_i = 64'h1004; inst_i = 0; size_i = 3; agu_br_mask_i = 0;
        tick();
        chk("mis_addr", agu_addr_o, 64'h1004);
        chk("mis_size3", agu_misalign_o, exp_mis3);
        size_i = 2;
        tick();
        chk("mis_size2", agu_misalign_o, 0);
        opb_i = 0; inst_i = 32'h0000_FFFF; size_i = 0;
        tick();
        chk("wrap_addr", agu_addr_o, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("wrap_mis", agu_misalign_o, 0);
        agu_vld_i = 0;

        // Fill buffer with CDB busy, 5th dropped, drain in order
        wb_rdy_i = 0;
        cmp(0, 64'hA0, 6'd1, 6'd8, 4'b0000);
        tick();
        chk("enq1_count", cb_count_o, 1);
        chk("enq1_wb_vld", wb_vld_o, 1);
        chk("enq1_ld_done", ld_done_o, 1);
        chk("enq1_result", result_o, 64'hA0);
        chk("enq1_rob", rob_idx_o, 8);
        for (int k = 1; k < 4; k++) begin
            cmp(k == 1, 64'hA0 + 64'(k), 6'(k + 1), 6'(k + 8), 4'b0000);
            tick();
        end
        chk("fill_count", cb_count_o, 4);
        chk("fill_full", cb_full_o, 1);
        cmp(0, 64'hEE, 6'd9, 6'd9, 4'b0000);
        tick();
        chk("drop_count", cb_count_o, 4);
        cmp_vld_i = 0; wb_rdy_i = 1;
        chk("drain0_result", result_o, 64'hA0);
        tick();
        chk("drain1_st_done", st_done_o, 1);
        chk("drain1_ld_done", ld_done_o, 0);
        chk("drain1_tag", dest_tag_o, 2);
        tick();
        chk("drain2_result", result_o, 64'hA2);
        tick();
        chk("drain3_result", result_o, 64'hA3);
        chk("drain3_count", cb_count_o, 1);
        tick();
        chk("drained_count", cb_count_o, 0);
        chk("drained_wb_vld", wb_vld_o, 0);
        chk("drained_result", result_o, 0);

        // Recovery leaves holes that drain without a grant
        wb_rdy_i = 0;
        cmp(0, 64'h10, 6'd1, 6'd1, 4'b0001); tick();
        cmp(0, 64'h11, 6'd2, 6'd2, 4'b0010); tick();
        cmp(0, 64'h12, 6'd3, 6'd3, 4'b0001); tick();
        cmp(0, 64'h13, 6'd4, 6'd4, 4'b0000); tick();
        cmp_vld_i = 0;
        rob_br_recovery_i = 1; rob_br_tag_fix_i = 4'b0001;
        tick();
        rob_br_recovery_i = 0; rob_br_tag_fix_i = 0;
        chk("hole_count4", cb_count_o, 4);
        chk("hole_head_vld", wb_vld_o, 0);
        tick();
        chk("hole_count3", cb_count_o, 3);
        chk("hole_wb1_vld", wb_vld_o, 1);
        chk("hole_wb1_result", result_o, 64'h11);
        chk("hole_wb1_mask", br_mask_o, 4'b0010);
        wb_rdy_i = 1;
        tick();
        chk("hole_count2", cb_count_o, 2);
        chk("hole2_vld", wb_vld_o, 0);
        tick();
        chk("hole_count1", cb_count_o, 1);
        chk("hole_wb3_result", result_o, 64'h13);
        tick();
        chk("hole_count0", cb_count_o, 0);

        // Resolved bits cleared on enqueue and in stored entries
        wb_rdy_i = 0;
        cmp(0, 64'h55, 6'd5, 6'd5, 4'b0110);
        rob_br_pred_correct_i = 1; rob_br_tag_fix_i = 4'b0100;
        tick();
        cmp_vld_i = 0;
        chk("clr_enq_mask", br_mask_o, 4'b0010);
        rob_br_tag_fix_i = 4'b0010;
        tick();
        rob_br_pred_correct_i = 0; rob_br_tag_fix_i = 0;
        chk("clr_entry_mask", br_mask_o, 4'b0000);
        wb_rdy_i = 1;
        tick();
        chk("clr_drained", cb_count_o, 0);

        // Incoming completion squashed by the same-cycle recovery
        cmp(0, 64'h66, 6'd6, 6'd6, 4'b0001);
        rob_br_recovery_i = 1; rob_br_tag_fix_i = 4'b0001;
        tick();
        cmp_vld_i = 0; rob_br_recovery_i = 0; rob_br_tag_fix_i = 0;
        chk("sq_in_count", cb_count_o, 0);
        chk("sq_in_wb_vld", wb_vld_o, 0);

        // Full buffer: pop + input dropped, then enqueue + pop
        wb_rdy_i = 0;
        for (int k = 0; k < 4; k++) begin
            cmp(0, 64'hB0 + 64'(k), 6'(k), 6'(k), 4'b0000);
            tick();
        end
        cmp(0, 64'h99, 6'd9, 6'd9, 4'b0000);
        wb_rdy_i = 1;
        chk("full_head", result_o, 64'hB0);
        tick();
        chk("full_pop_count", cb_count_o, 3);
        cmp(0, 64'h77, 6'd7, 6'd7, 4'b0000);
        tick();
        chk("enq_pop_count", cb_count_o, 3);
        cmp_vld_i = 0;
        chk("after_b2", result_o, 64'hB2);
        tick();
        chk("after_b3", result_o, 64'hB3);
        tick();
        chk("after_77", result_o, 64'h77);
        tick();
        chk("after_empty", cb_count_o, 0);

        // Reset mid-operation
        wb_rdy_i = 0;
        cmp(0, 64'hC0, 6'd1, 6'd1, 4'b0000); tick();
        cmp(0, 64'hC1, 6'd2, 6'd2, 4'b0000);
        agu_vld_i = 1; opb_i = 64'h40; inst_i = 0;
        tick();
        cmp_vld_i = 0; agu_vld_i = 0;
        rst = 1;
        tick();
        rst = 0;
        chk("mid_rst_count", cb_count_o, 0);
        chk("mid_rst_wb_vld", wb_vld_o, 0);
        chk("mid_rst_agu_vld", agu_vld_o, 0);
        chk("mid_rst_agu_addr", agu_addr_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/fu_ldst_cb.md
# fu_ldst_cb

Parametrised load/store execute stage: registered address generation (AGU) toward the LSQ, plus a DEPTH-entry completion buffer between LSQ completions and the CDB/ROB writeback port. Both halves track branch masks: they squash on mispredict recovery and clear resolved bits on correct prediction. It lets the LSQ complete loads/stores while the CDB is busy, instead of stalling the whole unit.

## Interface
- DATA_W, 64, data/address width
- PRF_IDX_W, 6, physical register tag width
- ROB_IDX_W, 5, ROB index width (ports carry ROB_IDX_W+1 bits incl. wrap bit)
- BR_MASK_W, 4, branch mask width
- DEPTH, 4, completion buffer entries (power of two, >=2)

Reset and clock: reset rst, synchronous, active-high; clock clk.

- rob_br_recovery_i / rob_br_pred_correct_i  in  1 / 1  branch resolved mispredicted / correct
- rob_br_tag_fix_i  in  BR_MASK_W  one-hot resolved branch bit
- agu_vld_i / agu_is_st_i  in  1 / 1  issue valid; 1 = store
- opa_i / opb_i  in  DATA_W  store data / base address
- inst_i  in  32  instruction; disp = sign-extended inst_i[15:0]
- size_i  in  2  log2 access bytes (0..3)
- agu_br_mask_i  in  BR_MASK_W  issuing op's mask
- agu_stall_i  in  1  LSQ cannot accept; AGU register holds
- agu_vld_o / agu_is_st_o  out  1 / 1  registered issue to LSQ
- agu_addr_o / agu_st_data_o  out  DATA_W  opb_i+disp / opa_i, registered
- agu_br_mask_o  out  BR_MASK_W  registered mask
- agu_misalign_o  out  1  address not size-aligned (see Configuration)
- cmp_vld_i / cmp_is_st_i  in  1 / 1  LSQ completion; 1 = store
- cmp_data_i  in  DATA_W  load result (ignored for stores)
- cmp_dest_tag_i  in  PRF_IDX_W;  cmp_rob_idx_i  in  ROB_IDX_W+1;  cmp_br_mask_i  in  BR_MASK_W
- cb_full_o  out  1  count == DEPTH
- cb_count_o  out  $clog2(DEPTH)+1  occupied entries
- wb_rdy_i  in  1  CDB grant
- wb_vld_o, ld_done_o, st_done_o  out  1  head valid; load / store flag (one-hot when valid)
- result_o  out  DATA_W;  dest_tag_o  out  PRF_IDX_W;  rob_idx_o  out  ROB_IDX_W+1;  br_mask_o  out  BR_MASK_W

## Operation
- AGU register:
  - Priority: rst → clear all.
  - Recovery with (agu_br_mask_o & fix) != 0 → clear all.
  - Recovery, no match → hold.
  - ~agu_stall_i → load inputs; vld = agu_vld_i & ~(recovery & agu_br_mask_i & fix).
  - Otherwise hold.
  - Address arithmetic is modulo 2^DATA_W.
- Mask clearing: on pred_correct, the fix bit is cleared in the AGU register (loading or holding), in every buffer entry, and in the enqueued mask.
- Completion buffer: circular FIFO with head/tail pointers and per-entry valid bits.
  - Enqueue when cmp_vld_i & ~cb_full_o; when full, the input is dropped (upstream must honour cb_full_o).
  - Incoming completion matching a recovery is not enqueued.
- Recovery in the buffer: entries with mask & fix != 0 have valid cleared and leave holes; count is unchanged.
  - An invalid head entry is popped automatically, one per cycle, without asserting wb_vld_o; this decrements count.
- Writeback: wb_vld_o = head valid. Pop on wb_vld_o & wb_rdy_i.
  - All wb outputs come from head-entry registers and are 0 when wb_vld_o = 0.
- Simultaneous enqueue+pop: count unchanged. Enqueue is allowed in the same cycle as a pop only if not full at cycle start.

## Timing
- Reset values: every output is 0; pointers, count and valid bits are 0.
- AGU latency: 1 cycle from agu_vld_i to agu_vld_o.
- Buffer latency: entry written at the cmp_vld_i edge; wb_vld_o asserts the next cycle if the buffer was empty.
- Throughput: 1 enqueue + 1 pop per cycle.
- Pointer wrap: modulo DEPTH.
- rst mid-operation discards everything within one cycle.

## Configuration
- LDST_MISALIGN_CHK_EN defined: agu_misalign_o is registered with the AGU and equals (addr & ((1<<size_i)-1)) != 0.
- LDST_MISALIGN_CHK_EN undefined: agu_misalign_o is tied to 0 and no check logic is built.

## Structure
- Shared package ldst_pkg holds:
  - typedef cb_entry_t {vld, is_st, data, dest_tag, rob_idx, br_mask};
  - function br_squash(mask, fix).
- Natural sub-module: ldst_cmp_fifo (buffer, pointers, squash/clear logic). The AGU stays in the top.

## Test plan
- Issue load, opb=0x1000, inst[15:0]=0xFFF8 → next cycle agu_addr_o=0xFF8, agu_vld_o=1.
- agu_stall_i held 3 cycles with a pred_correct for bit 0 during the stall → agu_vld_o held, agu_br_mask_o 0b0011→0b0010.
- Enqueue 4 completions with wb_rdy_i=0 → cb_full_o=1, count=4; a 5th is dropped; wb_rdy_i=1 drains in order over 4 cycles.
- Buffer holds masks 0b0001, 0b0010, 0b0001, 0b0000; recovery fix=0b0001 → only the entries with masks 0b0010 and 0b0000 reach writeback, with count decrementing through the holes.
- Full buffer with simultaneous pop and cmp_vld_i → input dropped, count 4→3; in the next cycle, enqueue+pop leaves count at 3.
- With LDST_MISALIGN_CHK_EN: addr=0x1004, size=3 → agu_misalign_o=1; size=2 → 0. Without the macro, always 0.
